// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle unsigned MUL / MULHU / DIVU / REMU controller.
// The block has no adder of its own. It borrows the shared 32-bit ALU
// through AluSrcA/AluSrcB/AluControl and reads back the combinational
// AluResult.
//
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   flush           cancels the in-flight op and any pending response
//   ReqValid/ReqReady, Op, OpA, OpB      request handshake and operands
//   RespValid/RespReady, Result          response handshake and result
//   Busy            high in RUN and DONE; the hazard unit stalls on it
//   AluOwn          high in RUN; steers the execute-stage ALU mux here
//   AluSrcA/AluSrcB/AluControl/AluResult  borrowed ALU interface
module mdu_sequencer #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [1:0]   Op,
  input  logic [N-1:0] OpA,
  input  logic [N-1:0] OpB,
  output logic         RespValid,
  input  logic         RespReady,
  output logic [N-1:0] Result,
  output logic         Busy,
  output logic         AluOwn,
  output logic [N-1:0] AluSrcA,
  output logic [N-1:0] AluSrcB,
  output logic [2:0]   AluControl,
  input  logic [N-1:0] AluResult
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  b_q, b_d;
  // h holds the product high half (MUL) or the partial remainder R (DIV).
  // l holds the product low half / multiplier (MUL) or the quotient Q (DIV).
  logic [N-1:0]  h_q, h_d;
  logic [N-1:0]  l_q, l_d;
  logic [N-1:0]  res_q, res_d;

  logic [N-1:0]  s_div;
  logic          mul_carry;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    h_d       = h_q;
    l_d       = l_q;
    res_d     = res_q;
    AluSrcA   = '0;
    AluSrcB   = '0;
    mul_carry = 1'b0;
    s_div     = {h_q[N-2:0], l_q[N-1]};

    case (state_q)
      S_IDLE: begin
        // Flush wins over a same-cycle request.
        if (ReqValid && !flush) begin
          op_d = Op;
          b_d  = OpB;
          if (Op[1] && (OpB == '0)) begin
            // Divide by zero resolves immediately without using the ALU.
            state_d = S_DONE;
            res_d   = Op[0] ? OpA : '1;
          end else begin
            state_d = S_RUN;
            cnt_d   = '0;
            h_d     = '0;
            l_d     = OpA;
          end
        end
      end

      S_RUN: begin
        if (op_q[1]) begin
          // Restoring divide: the ALU computes S - B via S + (~B + 1).
          // R[31] set means the shifted remainder exceeds 32 bits, so it
          // is certainly >= B even though S alone may not compare so.
          AluSrcA = s_div;
          AluSrcB = ~b_q + 1'b1;
          if (h_q[N-1] || (s_div >= b_q)) begin
            h_d = AluResult;
            l_d = {l_q[N-2:0], 1'b1};
          end else begin
            h_d = s_div;
            l_d = {l_q[N-2:0], 1'b0};
          end
        end else begin
          // Shift-add multiply; the carry out of H + B is recovered from
          // unsigned wrap detection because the ALU has no carry output.
          AluSrcA   = h_q;
          AluSrcB   = l_q[0] ? b_q : '0;
          mul_carry = (AluResult < h_q);
          h_d       = {mul_carry, AluResult[N-1:1]};
          l_d       = {AluResult[0], l_q[N-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d = S_DONE;
          // Op[0] selects the h register for both MULHU and REMU.
          res_d   = op_q[0] ? h_d : l_d;
        end
        if (flush) state_d = S_IDLE;
      end

      S_DONE: begin
        if (flush || RespReady) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      h_q     <= h_d;
      l_q     <= l_d;
      res_q   <= res_d;
    end
  end

  assign ReqReady   = (state_q == S_IDLE);
  assign RespValid  = (state_q == S_DONE);
  assign Busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign AluOwn     = (state_q == S_RUN);
  assign AluControl = 3'b000;
  assign Result     = res_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural 32-bit adder as the ALU.
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        reset_n, flush, ReqValid, ReqReady, RespValid, RespReady;
  logic        Busy, AluOwn;
  logic [1:0]  Op;
  logic [31:0] OpA, OpB, Result, AluSrcA, AluSrcB, AluResult;
  logic [2:0]  AluControl;

  int checks = 0;
  int failures = 0;
  int ctl_err = 0;
  int lat, own;
  logic [31:0] a0, b0, held;

  localparam logic [1:0] OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11;

  // ALU model: add only.
  assign AluResult = (AluControl == 3'b000) ? (AluSrcA + AluSrcB) : 32'hDEAD_BEEF;

  mdu_sequencer #(.N(32), .CW(6)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .Op(Op), .OpA(OpA), .OpB(OpB),
    .RespValid(RespValid), .RespReady(RespReady), .Result(Result),
    .Busy(Busy), .AluOwn(AluOwn), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .AluControl(AluControl), .AluResult(AluResult)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; it is accepted if the DUT is idle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; OpA = a; OpB = b; ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    // Scramble operands to show only the latched values matter.
    OpA = 32'h1234_5678; OpB = 32'h0; Op = 2'b11;
  endtask

  // Samples after the acceptance edge; lat is the sample index where
  // RespValid is first seen (1 = the cycle straight after acceptance).
  task automatic wait_resp();
    lat = 1; own = 0; a0 = AluSrcA; b0 = AluSrcB;
    while (!RespValid && lat < 100) begin
      if (AluOwn) own++;
      if (AluControl !== 3'b000) ctl_err++;
      step();
      lat++;
    end
  endtask

  task automatic take_resp();
    RespReady = 1'b1;
    step();
    RespReady = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; ReqValid = 1'b0; RespReady = 1'b0;
    Op = 2'b00; OpA = '0; OpB = '0;
    step(); step();
    chk("rst_reqready", {31'b0, ReqReady}, 32'd1);
    chk("rst_respvalid", {31'b0, RespValid}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_aluown", {31'b0, AluOwn}, 32'd0);
    chk("rst_srca", AluSrcA, 32'd0);
    chk("rst_srcb", AluSrcB, 32'd0);
    chk("rst_ctl", {29'b0, AluControl}, 32'd0);
    reset_n = 1'b1;
    step();

    // MUL 7*6: first iteration adds B because L[0]=1, H starts at 0.
    issue(OP_MUL, 32'd7, 32'd6);
    wait_resp();
    chk("mul_first_srca", a0, 32'd0);
    chk("mul_first_srcb", b0, 32'd6);
    chk("mul_lat", lat, 33);
    chk("mul_own", own, 32);
    chk("mul_result", Result, 32'd42);
    chk("mul_busy_done", {31'b0, Busy}, 32'd1);
    take_resp();
    chk("mul_after_valid", {31'b0, RespValid}, 32'd0);
    chk("mul_after_ready", {31'b0, ReqReady}, 32'd1);

    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp();
    chk("mulhu_ff", Result, 32'hFFFF_FFFE);
    take_resp();
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp();
    chk("mul_ff", Result, 32'h0000_0001);
    take_resp();

    // DIVU 100/7: first step S=0, ALU gets -7.
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_resp();
    chk("divu_first_srca", a0, 32'd0);
    chk("divu_first_srcb", b0, 32'hFFFF_FFF9);
    chk("divu_lat", lat, 33);
    chk("divu_100_7", Result, 32'd14);
    take_resp();
    issue(OP_REMU, 32'd100, 32'd7);
    wait_resp();
    chk("remu_100_7", Result, 32'd2);
    take_resp();
    issue(OP_DIVU, 32'h8000_0000, 32'd3);
    wait_resp();
    chk("divu_big", Result, 32'h2AAA_AAAA);
    take_resp();
    issue(OP_REMU, 32'h8000_0000, 32'd3);
    wait_resp();
    chk("remu_big", Result, 32'd2);
    take_resp();

    // Divide by zero resolves straight to DONE.
    issue(OP_DIVU, 32'd5, 32'd0);
    chk("div0_aluown", {31'b0, AluOwn}, 32'd0);
    wait_resp();
    chk("div0_lat", lat, 1);
    chk("div0_own", own, 0);
    chk("div0_result", Result, 32'hFFFF_FFFF);
    take_resp();
    issue(OP_REMU, 32'd5, 32'd0);
    wait_resp();
    chk("rem0_lat", lat, 1);
    chk("rem0_result", Result, 32'd5);
    take_resp();

    // Backpressure: response held while a competing request is presented.
    issue(OP_MUL, 32'd9, 32'd9);
    wait_resp();
    held = Result;
    chk("bp_result", held, 32'd81);
    Op = OP_DIVU; OpA = 32'd50; OpB = 32'd5; ReqValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", Result, 32'd81);
      chk("bp_reqready", {31'b0, ReqReady}, 32'd0);
      chk("bp_valid", {31'b0, RespValid}, 32'd1);
    end
    ReqValid = 1'b0;
    take_resp();
    chk("bp_done_valid", {31'b0, RespValid}, 32'd0);
    chk("bp_done_busy", {31'b0, Busy}, 32'd0);
    chk("bp_done_ready", {31'b0, ReqReady}, 32'd1);

    // Flush in RUN at count 15.
    issue(OP_MUL, 32'd11, 32'd13);
    for (int i = 0; i < 15; i++) step();
    chk("fl_pre_own", {31'b0, AluOwn}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_busy", {31'b0, Busy}, 32'd0);
    chk("fl_ready", {31'b0, ReqReady}, 32'd1);
    chk("fl_srca", AluSrcA, 32'd0);
    own = 0;
    for (int i = 0; i < 40; i++) begin
      if (RespValid) own++;
      step();
    end
    chk("fl_no_resp", own, 0);

    // Flush in IDLE blocks the same-cycle request.
    flush = 1'b1;
    issue(OP_MUL, 32'd2, 32'd2);
    flush = 1'b0;
    chk("fl_idle_busy", {31'b0, Busy}, 32'd0);

    issue(OP_MUL, 32'd3, 32'd4);
    wait_resp();
    chk("fl_next_lat", lat, 33);
    chk("fl_next_result", Result, 32'd12);
    take_resp();

    // Reset mid-RUN.
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    step();
    chk("mrst_busy", {31'b0, Busy}, 32'd0);
    chk("mrst_own", {31'b0, AluOwn}, 32'd0);
    chk("mrst_valid", {31'b0, RespValid}, 32'd0);
    chk("mrst_result", Result, 32'd0);
    chk("mrst_srcb", AluSrcB, 32'd0);
    reset_n = 1'b1;
    own = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (RespValid) own++;
    end
    chk("mrst_no_resp", own, 0);
    chk("mrst_ready", {31'b0, ReqReady}, 32'd1);

    chk("alu_ctl_add_only", ctl_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle unsigned multiply/divide controller for the 32-bit ALU.
- Performs its arithmetic through an external ALU instance. It drives that ALU's SrcA/SrcB/ALUControl inputs and consumes its combinational ALUResult.
- Sits beside the execute stage: the hazard unit stalls the pipeline while Busy is high, and the execute-stage operand mux hands the ALU to this block while AluOwn is high.
- Implements MUL, MULHU, DIVU, REMU with valid/ready request and response handshakes.

Parameters:
- N, 32, datapath width. Only 32 is supported; this matches the ALU.
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous cancel of the in-flight op (pipeline flush).
- ReqValid  input  1  request valid.
- ReqReady  output  1  high only in IDLE.
- Op  input  2  operation select: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
- OpA  input  N  multiplicand / dividend.
- OpB  input  N  multiplier / divisor.
- RespValid  output  1  result valid.
- RespReady  input  1  consumer accepts result.
- Result  output  N  operation result.
- Busy  output  1  high in RUN and DONE.
- AluOwn  output  1  high in RUN only; the ALU mux selects this block.
- AluSrcA  output  N  to ALU SrcA.
- AluSrcB  output  N  to ALU SrcB.
- AluControl  output  3  to ALU control; only 000 (add) is ever driven.
- AluResult  input  N  from ALU, same cycle (combinational).

Behaviour:
- Reset (reset_n=0 at an edge):
  - State returns to IDLE and the counter to 0.
  - RespValid=0, Result=0, Busy=0, AluOwn=0, AluSrcA=0, AluSrcB=0, AluControl=000.
  - Reset takes priority over flush and over every handshake.
- States:
  - IDLE: ReqReady=1. Accept on ReqValid&ReqReady at an edge; latch Op, A, B.
    - DIV/REM with OpB==0 goes to DONE directly.
    - Every other op goes to RUN with count=0.
  - RUN: 32 iterations, one per cycle. Count increments each cycle; after the iteration with count==31, go to DONE.
  - DONE: RespValid=1; Result is stable and held. On RespValid&RespReady, go to IDLE.
    - No new request is accepted in the same cycle as the response; ReqReady stays 0 in DONE.
- Multiply (64-bit P = {H, L}, initialised H=0, L=OpA, multiplier bit taken from L[0]):
  - Each cycle: AluSrcA = H, AluSrcB = L[0] ? B : 0, AluControl = 000.
  - Carry c = (AluResult < H), computed locally as an unsigned compare.
  - Update: P <= {c, AluResult, L} >> 1, keeping the low 64 bits.
  - MUL returns L; MULHU returns H.
- Divide (restoring; R=0, Q=OpA):
  - Each cycle: S = {R[30:0], Q[31]}; msb = R[31].
  - AluSrcA = S, AluSrcB = B (two's-complement negated locally), AluControl = 000. AluResult = S−B mod 2^32.
  - If msb | (S >= B): R <= AluResult and shift 1 into Q. Otherwise R <= S and shift 0 into Q.
  - DIVU returns Q; REMU returns R.
- Divide by zero: DIVU returns 0xFFFFFFFF and REMU returns OpA. No RUN cycles are spent.
- Latency, with acceptance at edge t:
  - Normal op: RUN occupies cycles t+1..t+32; RespValid rises at t+33.
  - Divide by zero: RespValid rises at t+1.
- When not in RUN: AluSrcA = AluSrcB = 0 and AluControl = 000. AluOwn is registered-state decoded and glitch-free.
- Flush at an edge:
  - In RUN or DONE: go to IDLE and drop the op and any pending response; RespValid=0 next cycle.
  - In IDLE: flush has priority over acceptance, so the same-cycle request is not accepted.
- Back-to-back: after response acceptance at edge u, the next request is accepted no earlier than edge u+1.
- Op/OpA/OpB changes while not in IDLE are ignored; the operands latched at acceptance are used.

Test Plan:
- Reset, then MUL OpA=7 OpB=6 accepted at t → RespValid rises at t+33, Result=42. AluOwn is high for exactly 32 cycles. AluControl is 000 throughout.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → Result=0xFFFFFFFE. Then MUL with the same operands → Result=0x00000001.
- DIVU 100/7 → 14 at t+33; REMU 100/7 → 2. DIVU 0x80000000/3 → 0x2AAAAAAA; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF at t+1 with AluOwn never high; REMU 5/0 → 5 at t+1.
- Backpressure: RespReady held low for 10 cycles after RespValid. Result stays constant, ReqReady=0, and a new ReqValid is ignored until acceptance. The op completes one cycle after RespReady=1.
- Flush at RUN count 15 → IDLE next cycle, no RespValid. The next request MUL 3×4 → 12.
- reset_n=0 mid-RUN → all outputs at reset values the next cycle and no stale response.
